// File: rtl/risc8_dram_pkg.sv
// Shared definitions for the RISC8 data-RAM host loader: default sizes,
// transfer state encoding and the circular address advance.
package risc8_dram_pkg;

  localparam int DEF_WORD_DEPTH = 70;
  localparam int DEF_AW         = 7;
  localparam int DEF_DW         = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Next word address, wrapping from the last physical word back to 0.
  function automatic logic [31:0] wrap_next(input logic [31:0] a, input logic [31:0] depth);
    return (a == depth - 32'd1) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/dram_dma_ctr.sv
// Word address and remaining-count registers for a host transfer, with the
// wrap rule applied on every beat and a flag marking the final beat.
module dram_dma_ctr
  import risc8_dram_pkg::*;
#(
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int AW         = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          advance,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [AW-1:0] remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= len;
    end else if (advance) begin
      addr      <= AW'(wrap_next(32'(addr), 32'(WORD_DEPTH)));
      remaining <= remaining - AW'(1);
    end
  end

  assign last = (remaining == AW'(1));

endmodule

// File: rtl/dram_dma.sv
// Multiplexes the data RAM port between the CPU core and a host fill/dump
// engine; the core is stalled only while a transfer owns the port.
module dram_dma
  import risc8_dram_pkg::*;
#(
  parameter int WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] core_address,
  input  logic          core_we,
  input  logic [DW-1:0] core_din,
  output logic [DW-1:0] core_dout,
  output logic          core_stall,
  output logic [AW-1:0] mem_address,
  output logic          mem_we,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(WORD_DEPTH);

  state_t        state;
  logic [AW-1:0] addr;
  logic          last;
  logic          accept;
  logic          reject;
  logic          empty;
  logic          load;
  logic          beat;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign reject    = ({1'b0, cmd_base} >= DEPTH_EXT);
  assign empty     = (cmd_len == '0);
  assign load      = accept && !reject && !empty;
  assign beat      = ((state == ST_FILL) && wdata_valid) ||
                     ((state == ST_DUMP) && rdata_ready);

  dram_dma_ctr #(
    .WORD_DEPTH(WORD_DEPTH),
    .AW        (AW)
  ) u_ctr (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .advance(beat),
    .base   (cmd_base),
    .len    (cmd_len),
    .addr   (addr),
    .last   (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      core_stall <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            if (reject || empty) begin
              // Rejected or empty commands never take the port from the core.
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= reject;
            end else begin
              state      <= cmd_write ? ST_FILL : ST_DUMP;
              core_stall <= 1'b1;
              busy       <= 1'b1;
            end
          end
        end
        ST_FILL, ST_DUMP: begin
          if (beat && last) begin
            state      <= ST_DONE;
            core_stall <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            err        <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Core owns the port except while a transfer is moving words.
  always_comb begin
    mem_address = core_address;
    mem_we      = core_we;
    mem_din     = core_din;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    unique case (state)
      ST_FILL: begin
        mem_address = addr;
        mem_din     = wdata;
        mem_we      = wdata_valid;
        wdata_ready = 1'b1;
      end
      ST_DUMP: begin
        mem_address = addr;
        mem_we      = 1'b0;
        rdata_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign rdata     = mem_dout;
  assign core_dout = mem_dout;

endmodule

// File: tb/tb_dram_dma.sv
// Randomized self-checking bench for dram_dma: a behavioural RAM image is
// updated from the command rules and compared against the physical RAM.
module tb_dram_dma;

  localparam int DEPTH = 70;
  localparam int AW    = 7;
  localparam int DW    = 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] core_address;
  logic          core_we;
  logic [DW-1:0] core_din;
  logic [DW-1:0] core_dout;
  logic          core_stall;
  logic [AW-1:0] mem_address;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_base;
  logic [AW-1:0] cmd_len;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [DW-1:0] wdata;
  logic          rdata_valid;
  logic          rdata_ready;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] ram   [0:DEPTH-1];
  logic [DW-1:0] model [0:DEPTH-1];

  dram_dma #(
    .WORD_DEPTH(DEPTH),
    .AW        (AW),
    .DW        (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_address(core_address),
    .core_we     (core_we),
    .core_din    (core_din),
    .core_dout   (core_dout),
    .core_stall  (core_stall),
    .mem_address (mem_address),
    .mem_we      (mem_we),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical RAM: asynchronous read, write on the rising edge.
  always @(posedge clk) begin
    if (mem_we && (int'(mem_address) < DEPTH)) ram[mem_address] <= mem_din;
  end
  assign mem_dout = (int'(mem_address) < DEPTH) ? ram[mem_address] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_compare(input string tag);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) bad++;
    check(tag, bad, 0);
  endtask

  // pat: 0 = stream always ready, 1 = alternate 1,0,1,..., 2 = random.
  // dseq != 0 makes fill data dseq, dseq+1, ... instead of random.
  task automatic run_cmd(input bit wr, input int base, input int len, input int pat,
                         input bit core_hit, input logic [7:0] dseq);
    int t0;
    int idx;
    int stalls;
    int n;
    int a;
    bit go;
    logic [7:0] d;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_base  = AW'(base);
    cmd_len   = AW'(len);
    if (core_hit) begin
      core_address = 7'h30;
      core_din     = 8'h55;
      core_we      = 1'b1;
      model[8'h30] = 8'h55;
    end
    t0 = cyc;
    #1;
    check("accept_mem_we", mem_we, core_we);
    check("accept_mem_address", mem_address, core_address);
    tick();
    cmd_valid = 1'b0;
    core_we   = 1'b0;
    stalls    = 0;
    if (base >= DEPTH || len == 0) begin
      #1;
      check("short_done", done, 1);
      check("short_err", err, (base >= DEPTH) ? 1 : 0);
      check("short_stall", core_stall, 0);
      check("short_mem_we", mem_we, 0);
      check("short_latency", cyc - t0, 1);
    end else begin
      idx = 0;
      n   = 0;
      while (idx < len) begin
        check("xfer_stall", core_stall, 1);
        check("xfer_busy", busy, 1);
        check("xfer_done", done, 0);
        go = (pat == 0) ? 1'b1 : (pat == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
        d  = (dseq != 0) ? 8'(dseq + 8'(idx)) : 8'($urandom);
        a  = (base + idx) % DEPTH;
        core_address = 7'h31;
        core_din     = 8'h66;
        core_we      = 1'($urandom_range(0, 1));
        if (wr) begin
          wdata_valid = go;
          wdata       = d;
        end else begin
          rdata_ready = go;
        end
        #1;
        check("xfer_mem_address", mem_address, a);
        if (wr) begin
          check("fill_mem_we", mem_we, go);
          check("fill_mem_din", mem_din, d);
          check("fill_wdata_ready", wdata_ready, 1);
        end else begin
          check("dump_mem_we", mem_we, 0);
          check("dump_rdata_valid", rdata_valid, 1);
          if (go) check("dump_rdata", rdata, model[a]);
        end
        if (go) begin
          if (wr) model[a] = d;
          idx++;
        end else begin
          stalls++;
        end
        n++;
        tick();
      end
      wdata_valid = 1'b0;
      rdata_ready = 1'b0;
      core_we     = 1'b0;
      check("end_done", done, 1);
      check("end_err", err, 0);
      check("end_stall", core_stall, 0);
      check("end_busy", busy, 0);
      check("end_cmd_ready", cmd_ready, 0);
      check("end_latency", cyc - t0, len + stalls + 1);
    end
    tick();
    check("after_done", done, 0);
    check("after_cmd_ready", cmd_ready, 1);
    ram_compare(wr ? "ram_after_fill" : "ram_after_dump");
    $display("cmd %s base=%0d len=%0d pat=%0d stalls=%0d", wr ? "fill" : "dump",
             base, len, pat, stalls);
  endtask

  initial begin
    reset        = 1'b1;
    core_address = '0;
    core_we      = 1'b0;
    core_din     = '0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_base     = '0;
    cmd_len      = '0;
    wdata_valid  = 1'b0;
    wdata        = '0;
    rdata_ready  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]   = 8'($urandom);
      model[i] = ram[i];
    end
    #2;
    reset = 1'b0;
    #1;
    // Core keeps the port during reset, including writes.
    core_address = 7'h05;
    core_din     = 8'h77;
    core_we      = 1'b1;
    model[5]     = 8'h77;
    #1;
    check("rst_core_stall", core_stall, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wdata_ready", wdata_ready, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_mem_address", mem_address, 7'h05);
    check("rst_mem_we", mem_we, 1);
    check("rst_mem_din", mem_din, 8'h77);
    tick();
    tick();
    core_we = 1'b0;
    reset   = 1'b1;
    tick();
    ram_compare("ram_reset_write");
    $display("reset released");

    run_cmd(1'b1, 8'h10, 4, 0, 1'b0, 8'hA0);
    check("ram_0x13", ram[8'h13], 8'hA3);
    run_cmd(1'b1, 68, 4, 0, 1'b0, 8'hC0);
    check("wrap_ram0", ram[0], 8'hC2);
    check("wrap_ram1", ram[1], 8'hC3);
    run_cmd(1'b0, 8'h20, 3, 1, 1'b0, 8'h00);
    run_cmd(1'b1, 70, 5, 0, 1'b0, 8'h00);
    run_cmd(1'b1, 8'h08, 0, 0, 1'b0, 8'h00);
    run_cmd(1'b1, 8'h10, 4, 2, 1'b1, 8'h00);
    check("core_write_0x30", ram[8'h30], 8'h55);

    // Reset mid-fill after 2 of 5 beats.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_base  = 7'h40;
    cmd_len   = 7'd5;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wdata_valid     = 1'b1;
      wdata           = 8'($urandom);
      model[8'h40 + i] = wdata;
      tick();
    end
    reset        = 1'b0;
    core_address = 7'h05;
    #1;
    check("midrst_stall", core_stall, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_mem_address", mem_address, 7'h05);
    check("midrst_mem_we", mem_we, 0);
    tick();
    reset       = 1'b1;
    wdata_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_done", done, 0);
      tick();
    end
    ram_compare("ram_after_midrst");
    $display("mid-transfer reset done");

    for (int k = 0; k < 30; k++) begin
      int b;
      int l;
      b = $urandom_range(0, 79);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 12);
      run_cmd(1'($urandom_range(0, 1)), b, l, 2, 1'b0, 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
